run_tracker: RTL and testbench
==============================

Name: run_tracker

Overview:
- Multi-channel run detector: each of N input channels runs an independent IDLE/RUN/LAST/TMO state machine.
- Per channel it produces:
  - a registered run indicator;
  - a one-cycle end-of-run pulse carrying the measured run length;
  - a short-run (glitch) flag;
  - a level timeout flag for runs that exceed a maximum length.
- Sits between raw sampled control strobes and downstream sequencers that need run lengths and clean edges.

Parameters:
- N, 4, number of independent channels (>=1).
- CNT_W, 8, run-length counter width per channel.
- MIN_RUN, 2, runs with length < MIN_RUN are flagged short. Legal range 1..MAX_RUN; 1 disables the flag.
- MAX_RUN, 10, run length at which the channel enters timeout. Legal range MIN_RUN..2^CNT_W-1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable. Low forces every channel to IDLE on the next edge.
- din  in  N  per-channel run input, sampled each edge.
- run_o  out  N  per-channel registered run indicator.
- fall_o  out  N  per-channel one-cycle end-of-run pulse.
- short_o  out  N  per-channel pulse, valid only with fall_o: run length < MIN_RUN.
- tmo_o  out  N  per-channel level flag, high while the channel is in timeout.
- len_o  out  N*CNT_W  per-channel run length. Channel i occupies bits [i*CNT_W +: CNT_W]. Updated only with fall_o, held otherwise.

Behaviour:
- Reset: one clock, synchronous active-high. Every channel goes to IDLE with cnt=0. run_o, fall_o, short_o, tmo_o and len_o are all 0 on the edge after rst is sampled high. Reset mid-run aborts the run; no fall_o pulse is produced.
- en low: on the next edge all channels go to IDLE and cnt=0. Outputs follow from IDLE (all flags 0, len_o held). No fall_o pulse. en has lower priority than rst.
- Per-channel FSM, 2-bit state. Encodings: IDLE=0, RUN=1, LAST=2, TMO=3.
  - IDLE: din=1 -> RUN, cnt=1. Otherwise stay in IDLE.
  - RUN, din=1, cnt<MAX_RUN: stay in RUN, cnt=cnt+1.
  - RUN, din=1, cnt==MAX_RUN: -> TMO, cnt held.
  - RUN, din=0: -> LAST, cnt held.
  - LAST: unconditionally -> IDLE. din is ignored in this state; a new run requires din=1 sampled in IDLE.
  - TMO: din=0 -> IDLE. Otherwise stay in TMO.
  - Any illegal state -> IDLE.
- Outputs are registered from the current state, one edge after the state is entered:
  - state==RUN -> run_o<=1.
  - state==LAST -> fall_o<=1, short_o<=(cnt<MIN_RUN), len_o<=cnt.
  - state==TMO -> tmo_o<=1.
  - All other cases: run_o, fall_o, short_o, tmo_o <= 0.
- Timing: din high for L edges (L<=MAX_RUN) starting at edge e0.
  - run_o is high for exactly L cycles, starting after e1.
  - fall_o pulses once after edge e0+L+1, with len_o=L.
- Timeout: din held high longer than MAX_RUN.
  - run_o is high for MAX_RUN cycles.
  - tmo_o rises the cycle after run_o falls and stays high until the edge after din is sampled low in TMO.
  - No fall_o and no len_o update for a timed-out run.
- cnt never exceeds MAX_RUN, so no wrap is possible.
- Channels are fully independent: simultaneous events on different channels are handled per channel with no interaction.

Decomposition:
- Package run_tracker_pkg:
  - 2-bit state typedef and the four encodings;
  - localparam for the illegal-state default;
  - elaboration-time parameter legality checks (MIN_RUN, MAX_RUN vs CNT_W).
- Sub-module run_tracker_chan: one channel's FSM, counter and output registers. Instantiated N times in a generate loop.
- The top level only fans out clk, rst and en, and packs len_o.

Test Plan:
All scenarios use N=4, CNT_W=8, MIN_RUN=2, MAX_RUN=10.
- Basic run: din[0] high for 3 edges -> run_o[0] high 3 cycles, then fall_o[0] pulse with len_o[7:0]=3 and short_o[0]=0. Other channels stay idle.
- Glitch: din[1] high for 1 edge -> run_o[1] high 1 cycle, then fall_o[1]=1 with short_o[1]=1 and len_o[15:8]=1.
- Timeout: din[2] high for 15 edges -> run_o[2] high 10 cycles, tmo_o[2] high until the edge after din falls. No fall_o[2] pulse; len_o[23:16] unchanged.
- Back-to-back: din[3] high 4 edges, low 1 edge, high 2 edges -> the second run starts only if din is sampled high in IDLE. The second rise, sampled during LAST, is ignored, so that run is measured from IDLE entry. Check len values 4, then 1.
- Reset mid-run: rst high while channel 0 is in RUN with cnt=5 -> all outputs 0 next cycle, no fall_o pulse, len_o=0.
- Enable drop: en low for 1 cycle during runs on all 4 channels -> all channels IDLE, no fall_o pulses. Runs restart only on din high after en returns high.

Source files
------------

// File: rtl/run_tracker_pkg.sv
// run_tracker shared types and constants.
// State encodings and parameter legality helper.
package run_tracker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_LAST = 2'd2;
  localparam state_t S_TMO  = 2'd3;

  // Recovery target for any unexpected state value.
  localparam state_t S_DFLT = S_IDLE;

  function automatic bit params_ok(
    input int min_run,
    input int max_run,
    input int cnt_w
  );
    longint lim;
    lim = (longint'(1) << cnt_w) - 1;
    return (cnt_w >= 1) && (min_run >= 1) &&
           (max_run >= min_run) &&
           (longint'(max_run) <= lim);
  endfunction

endpackage

// File: rtl/run_tracker_chan.sv
// run_tracker single channel.
// FSM, run counter and output registers.
module run_tracker_chan
  import run_tracker_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MIN_RUN = 2,
  parameter int MAX_RUN = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic             run_o,
  output logic             fall_o,
  output logic             short_o,
  output logic             tmo_o,
  output logic [CNT_W-1:0] len_o
);

  if (!params_ok(MIN_RUN, MAX_RUN, CNT_W)) begin : g_bad
    $error("run_tracker_chan: illegal MIN_RUN/MAX_RUN");
  end

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  // Next state and run length.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (din) begin
          state_nx = S_RUN;
          cnt_nx   = ONE_C;
        end
      end
      S_RUN: begin
        if (!din)
          state_nx = S_LAST;
        else if (cnt == MAX_C)
          state_nx = S_TMO;
        else
          cnt_nx = cnt + ONE_C;
      end
      S_LAST: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      S_TMO: begin
        if (!din) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_DFLT;
        cnt_nx   = '0;
      end
    endcase
  end

  // State and outputs; flags come from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      run_o   <= 1'b0;
      fall_o  <= 1'b0;
      short_o <= 1'b0;
      tmo_o   <= 1'b0;
      len_o   <= '0;
    end else if (!en) begin
      state   <= S_IDLE;
      cnt     <= '0;
      run_o   <= 1'b0;
      fall_o  <= 1'b0;
      short_o <= 1'b0;
      tmo_o   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      run_o   <= (state == S_RUN);
      fall_o  <= (state == S_LAST);
      short_o <= (state == S_LAST) && (cnt < MIN_C);
      tmo_o   <= (state == S_TMO);
      if (state == S_LAST)
        len_o <= cnt;
    end
  end

endmodule

// File: rtl/run_tracker.sv
// run_tracker top.
// N independent run-detector channels.
module run_tracker
  import run_tracker_pkg::*;
#(
  parameter int N       = 4,
  parameter int CNT_W   = 8,
  parameter int MIN_RUN = 2,
  parameter int MAX_RUN = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N-1:0]       din,
  output logic [N-1:0]       run_o,
  output logic [N-1:0]       fall_o,
  output logic [N-1:0]       short_o,
  output logic [N-1:0]       tmo_o,
  output logic [N*CNT_W-1:0] len_o
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    run_tracker_chan #(
      .CNT_W  (CNT_W),
      .MIN_RUN(MIN_RUN),
      .MAX_RUN(MAX_RUN)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .din    (din[i]),
      .run_o  (run_o[i]),
      .fall_o (fall_o[i]),
      .short_o(short_o[i]),
      .tmo_o  (tmo_o[i]),
      .len_o  (len_o[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_run_tracker.sv
// run_tracker bench.
// Directed table plus multi-cycle sequences.
module tb_run_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [3:0]  din = '0;
  logic [3:0]  run_o;
  logic [3:0]  fall_o;
  logic [3:0]  short_o;
  logic [3:0]  tmo_o;
  logic [31:0] len_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_tracker #(
    .N      (4),
    .CNT_W  (8),
    .MIN_RUN(2),
    .MAX_RUN(10)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .din    (din),
    .run_o  (run_o),
    .fall_o (fall_o),
    .short_o(short_o),
    .tmo_o  (tmo_o),
    .len_o  (len_o)
  );

  typedef struct {
    logic        r;
    logic        e;
    logic [3:0]  d;
    logic [3:0]  run;
    logic [3:0]  fall;
    logic [3:0]  shrt;
    logic [3:0]  tmo;
    logic [31:0] len;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input logic r, input logic e, input logic [3:0] d,
    input logic [3:0] rn, input logic [3:0] fl,
    input logic [3:0] sh, input logic [3:0] tm,
    input logic [31:0] ln
  );
    vec_t v;
    v.r = r; v.e = e; v.d = d;
    v.run = rn; v.fall = fl; v.shrt = sh;
    v.tmo = tm; v.len = ln;
    return v;
  endfunction

  task automatic chk4(input string nm, input string sig,
                      input logic [3:0] got,
                      input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got %b want %b", nm, sig, got, exp);
    end
  endtask

  // Drive one cycle, then compare all outputs after the edge.
  task automatic step(input string nm, input vec_t v);
    rst = v.r;
    en  = v.e;
    din = v.d;
    @(posedge clk);
    #1;
    chk4(nm, "run_o",   run_o,   v.run);
    chk4(nm, "fall_o",  fall_o,  v.fall);
    chk4(nm, "short_o", short_o, v.shrt);
    chk4(nm, "tmo_o",   tmo_o,   v.tmo);
    checks++;
    if (len_o !== v.len) begin
      errors++;
      $display("FAIL %s len_o got %h want %h", nm, len_o, v.len);
    end
  endtask

  logic [31:0] lh;
  logic [3:0]  er;
  logic [3:0]  et;

  initial begin
    // reset, ch0 run of 3, ch1 glitch, ch0/ch3 simultaneous
    tbl[0]  = mk(1, 1, 4'b0000, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 4'b0001, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 1, 4'b0001, 4'b0001, 0, 0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 4'b0001, 4'b0001, 0, 0, 0, 32'h0);
    tbl[4]  = mk(0, 1, 4'b0000, 4'b0001, 0, 0, 0, 32'h0);
    tbl[5]  = mk(0, 1, 4'b0000, 0, 4'b0001, 0, 0, 32'h3);
    tbl[6]  = mk(0, 1, 4'b0000, 0, 0, 0, 0, 32'h3);
    tbl[7]  = mk(0, 1, 4'b0010, 0, 0, 0, 0, 32'h3);
    tbl[8]  = mk(0, 1, 4'b0000, 4'b0010, 0, 0, 0, 32'h3);
    tbl[9]  = mk(0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 0,
                 32'h103);
    tbl[10] = mk(0, 1, 4'b0000, 0, 0, 0, 0, 32'h103);
    tbl[11] = mk(0, 1, 4'b1001, 0, 0, 0, 0, 32'h103);
    tbl[12] = mk(0, 1, 4'b0001, 4'b1001, 0, 0, 0, 32'h103);
    tbl[13] = mk(0, 1, 4'b0000, 4'b0001, 4'b1000, 4'b1000, 0,
                 32'h0100_0103);
    tbl[14] = mk(0, 1, 4'b0000, 0, 4'b0001, 0, 0,
                 32'h0100_0102);
    tbl[15] = mk(0, 1, 4'b0000, 0, 0, 0, 0, 32'h0100_0102);

    @(negedge clk);
    for (int i = 0; i < 16; i++)
      step($sformatf("tbl%0d", i), tbl[i]);

    // timeout on ch2: din high 15 edges
    lh = 32'h0100_0102;
    for (int k = 0; k <= 16; k++) begin
      er = (k >= 1 && k <= 10) ? 4'b0100 : 4'b0000;
      et = (k >= 11 && k <= 15) ? 4'b0100 : 4'b0000;
      step($sformatf("tmo%0d", k),
           mk(0, 1, (k < 15) ? 4'b0100 : 4'b0000,
              er, 0, 0, et, lh));
    end

    // back-to-back on ch3: high 4, low 1, high 2
    step("b2b0", mk(0, 1, 4'b1000, 0, 0, 0, 0, lh));
    step("b2b1", mk(0, 1, 4'b1000, 4'b1000, 0, 0, 0, lh));
    step("b2b2", mk(0, 1, 4'b1000, 4'b1000, 0, 0, 0, lh));
    step("b2b3", mk(0, 1, 4'b1000, 4'b1000, 0, 0, 0, lh));
    step("b2b4", mk(0, 1, 4'b0000, 4'b1000, 0, 0, 0, lh));
    step("b2b5", mk(0, 1, 4'b1000, 0, 4'b1000, 0, 0,
                    32'h0400_0102));
    step("b2b6", mk(0, 1, 4'b1000, 0, 0, 0, 0,
                    32'h0400_0102));
    step("b2b7", mk(0, 1, 4'b0000, 4'b1000, 0, 0, 0,
                    32'h0400_0102));
    step("b2b8", mk(0, 1, 4'b0000, 0, 4'b1000, 4'b1000, 0,
                    32'h0100_0102));
    step("b2b9", mk(0, 1, 4'b0000, 0, 0, 0, 0,
                    32'h0100_0102));

    // reset mid-run with ch0 at cnt=5
    step("rst0", mk(0, 1, 4'b0001, 0, 0, 0, 0, lh));
    for (int k = 1; k <= 4; k++)
      step($sformatf("rst%0d", k),
           mk(0, 1, 4'b0001, 4'b0001, 0, 0, 0, lh));
    step("rst5", mk(1, 1, 4'b0001, 0, 0, 0, 0, 32'h0));
    step("rst6", mk(0, 1, 4'b0000, 0, 0, 0, 0, 32'h0));
    step("rst7", mk(0, 1, 4'b0000, 0, 0, 0, 0, 32'h0));

    // enable drop with ch0 in LAST and others in RUN
    step("en0", mk(0, 1, 4'b1111, 0, 0, 0, 0, 32'h0));
    step("en1", mk(0, 1, 4'b1110, 4'b1111, 0, 0, 0, 32'h0));
    step("en2", mk(0, 0, 4'b1111, 0, 0, 0, 0, 32'h0));
    step("en3", mk(0, 1, 4'b1111, 0, 0, 0, 0, 32'h0));
    step("en4", mk(0, 1, 4'b0000, 4'b1111, 0, 0, 0, 32'h0));
    step("en5", mk(0, 1, 4'b0000, 0, 4'b1111, 4'b1111, 0,
                   32'h0101_0101));
    step("en6", mk(0, 1, 4'b0000, 0, 0, 0, 0,
                   32'h0101_0101));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
